// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB requester
// Holds the FSM state type, the default peripheral window, the slot
// index width and the slot numbers the peripherals are mapped to.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam logic [15:0] APB_BASE_HI = 16'h1000;
    localparam int          SLOT_W      = 4;

    localparam logic [SLOT_W-1:0] SLOT_RAM  = 4'd0;
    localparam logic [SLOT_W-1:0] SLOT_GPO  = 4'd1;
    localparam logic [SLOT_W-1:0] SLOT_GPI  = 4'd2;
    localparam logic [SLOT_W-1:0] SLOT_GPIO = 4'd3;
    localparam logic [SLOT_W-1:0] SLOT_UART = 4'd4;

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - combinational peripheral address decoder
// Ports:
//   addr   in  32  CPU byte address
//   mapped out 1   address falls inside the window and a populated slot
//   idx    out 4   slot index (addr[15:12]), meaningful only when mapped
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int          NSLV    = 5,
    parameter logic [15:0] BASE_HI = APB_BASE_HI
) (
    input  logic [31:0]       addr,
    output logic              mapped,
    output logic [SLOT_W-1:0] idx
);

    // Offset within a peripheral is not the bridge's concern.
    logic unused_offset;
    assign unused_offset = ^addr[11:0];

    assign idx    = addr[15:12];
    assign mapped = (addr[31:16] == BASE_HI) && ({28'd0, addr[15:12]} < NSLV);

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB3 requester for the core's data-memory port
// Ports:
//   PCLK, PRESET              clock, asynchronous active-high reset
//   transfer/write/addr/wdata CPU request (sampled in IDLE or on completion)
//   rdata/ready/err           single-cycle completion towards the CPU
//   PADDR/PWRITE/PWDATA       latched request on the APB side
//   PSEL/PENABLE              one-hot select and ACCESS-phase flag
//   PRDATA/PREADY             per-slot read data and ready
module apb_master
    import apb_pkg::*;
#(
    parameter int          NSLV    = 5,
    parameter logic [15:0] BASE_HI = APB_BASE_HI,
    parameter int          TIMEOUT = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  transfer,
    input  logic                  write,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  err,
    output logic [31:0]           PADDR,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    output logic                  PENABLE,
    output logic [NSLV-1:0]       PSEL,
    input  logic [NSLV-1:0][31:0] PRDATA,
    input  logic [NSLV-1:0]       PREADY
);

    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    apb_state_t        state_q, state_d;
    logic [31:0]       paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic              mapped_q, mapped_d;
    logic [SLOT_W-1:0] idx_q, idx_d;
    logic [3:0]        wcnt_q, wcnt_d;

    logic              dec_mapped;
    logic [SLOT_W-1:0] dec_idx;
    logic              sel_ready;
    logic [31:0]       sel_rdata;
    logic              load;

    apb_addr_decoder #(
        .NSLV    (NSLV),
        .BASE_HI (BASE_HI)
    ) u_dec (
        .addr   (addr),
        .mapped (dec_mapped),
        .idx    (dec_idx)
    );

    // Only the latched slot's PREADY/PRDATA are ever looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (idx_q == SLOT_W'(i)) begin
                sel_ready = PREADY[i];
                sel_rdata = PRDATA[i];
            end
        end
    end

    // Select and enable come straight from registers so they cannot glitch.
    always_comb begin
        PSEL = '0;
        if (mapped_q && (state_q != IDLE)) begin
            for (int i = 0; i < NSLV; i++) begin
                PSEL[i] = (idx_q == SLOT_W'(i));
            end
        end
    end

    assign PENABLE = (state_q == ACCESS);
    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        load    = 1'b0;
        ready   = 1'b0;
        err     = 1'b0;
        rdata   = '0;
        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    load    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                wcnt_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (!mapped_q) begin
                    ready = 1'b1;
                    err   = 1'b1;
                end else if (sel_ready) begin
                    ready = 1'b1;
                    rdata = pwrite_q ? 32'd0 : sel_rdata;
                end else if (wcnt_q == WAIT_LAST) begin
                    ready = 1'b1;
                    err   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
                // A request present on the completion cycle starts the
                // next SETUP immediately, with no idle gap.
                if (ready) begin
                    load    = transfer;
                    state_d = transfer ? SETUP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign paddr_d  = load ? addr       : paddr_q;
    assign pwrite_d = load ? write      : pwrite_q;
    assign pwdata_d = load ? wdata      : pwdata_q;
    assign mapped_d = load ? dec_mapped : mapped_q;
    assign idx_d    = load ? dec_idx    : idx_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            mapped_q <= 1'b0;
            idx_q    <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            mapped_q <= mapped_d;
            idx_q    <= idx_d;
            wcnt_q   <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master
module tb_apb_master;

    localparam int NSLV    = 5;
    localparam int TIMEOUT = 16;

    logic                  PCLK = 1'b0;
    logic                  PRESET;
    logic                  transfer;
    logic                  write;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic                  ready;
    logic                  err;
    logic [31:0]           PADDR;
    logic                  PWRITE;
    logic [31:0]           PWDATA;
    logic                  PENABLE;
    logic [NSLV-1:0]       PSEL;
    logic [NSLV-1:0][31:0] PRDATA;
    logic [NSLV-1:0]       PREADY;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat_cfg = 0;
    int          acc_n;
    logic [4:0]  noise = '0;
    logic [31:0] slot_data [NSLV];

    apb_master #(
        .NSLV    (NSLV),
        .BASE_HI (16'h1000),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    always #5 PCLK = ~PCLK;

    // Slave model: the selected slot raises PREADY once it has seen lat_cfg
    // ACCESS cycles; unselected slots drive random noise on PREADY.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)                acc_n <= 0;
        else if (PENABLE && !ready) acc_n <= acc_n + 1;
        else                       acc_n <= 0;
    end

    always_comb begin
        for (int i = 0; i < NSLV; i++) begin
            PRDATA[i] = slot_data[i];
            PREADY[i] = PSEL[i] ? (acc_n >= lat_cfg) : noise[i];
        end
    end

    typedef struct {
        string       name;
        logic [31:0] a;
        logic        w;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rd;
        logic [4:0]  psel;
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request at a negedge and follows it to completion.
    // e_cyc is the cycle of ready counted from the transfer cycle (= 0).
    task automatic run_xfer(input string name, input logic [31:0] a, input logic w,
                            input logic [31:0] wd, input int lat, input logic [31:0] rd,
                            input logic [4:0] e_psel, input int e_cyc,
                            input logic e_err, input logic [31:0] e_rdata);
        int got = -1;
        int bad = 0;
        lat_cfg = lat;
        noise   = 5'($urandom);
        for (int i = 0; i < NSLV; i++) slot_data[i] = $urandom;
        if (a[15:12] < NSLV) slot_data[a[15:12]] = rd;
        addr = a; write = w; wdata = wd; transfer = 1'b1;
        @(posedge PCLK); #1;
        transfer = 1'b0; addr = $urandom; wdata = $urandom; write = 1'($urandom);
        for (int c = 1; c <= 40; c++) begin
            @(negedge PCLK);
            if (PSEL !== e_psel || PENABLE !== (c >= 2) || PADDR !== a ||
                PWRITE !== w || PWDATA !== wd) bad++;
            if (ready === 1'b1) begin
                got = c;
                check({name, "_err"}, 32'(err), 32'(e_err));
                check({name, "_rdata"}, rdata, e_rdata);
                break;
            end
        end
        check({name, "_latency"}, 32'(got), 32'(e_cyc));
        check({name, "_phase_bad_cycles"}, 32'(bad), 32'd0);
        @(negedge PCLK);
        check({name, "_idle_after"}, {25'd0, PSEL, PENABLE, ready}, 32'd0);
    endtask

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, base, rd, wd, e_rdata;
        logic        w, mapped, ok;
        logic [3:0]  slot;
        logic [4:0]  e_psel;
        int          lat, n;
        logic        saw_ready;

        tbl[0] = '{"gpi_read",    32'h1000_2004, 1'b0, 32'h0,         1,    32'h0000_00A5, 5'b00100, 3,  1'b0, 32'h0000_00A5};
        tbl[1] = '{"gpo_write",   32'h1000_1000, 1'b1, 32'h0000_00FF, 0,    32'h1234_5678, 5'b00010, 2,  1'b0, 32'h0};
        tbl[2] = '{"unmapped",    32'h2000_0000, 1'b0, 32'h0,         0,    32'hFFFF_FFFF, 5'b00000, 2,  1'b1, 32'h0};
        tbl[3] = '{"timeout",     32'h1000_3000, 1'b0, 32'h0,         1000, 32'h0000_0055, 5'b01000, 17, 1'b1, 32'h0};
        tbl[4] = '{"slot5_unmap", 32'h1000_5000, 1'b0, 32'h0,         0,    32'h1111_1111, 5'b00000, 2,  1'b1, 32'h0};
        tbl[5] = '{"last_wait",   32'h1000_4008, 1'b0, 32'h0,         15,   32'hCAFE_F00D, 5'b10000, 17, 1'b0, 32'hCAFE_F00D};
        tbl[6] = '{"ram_read",    32'h1000_0FFC, 1'b0, 32'h0,         0,    32'h8765_4321, 5'b00001, 2,  1'b0, 32'h8765_4321};
        tbl[7] = '{"slotF_unmap", 32'h1000_F000, 1'b1, 32'hABCD,      0,    32'h2222_2222, 5'b00000, 2,  1'b1, 32'h0};

        for (int i = 0; i < NSLV; i++) slot_data[i] = '0;
        PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge PCLK);
        check("reset_outputs", {25'd0, PSEL, PENABLE, ready, err}, 32'd0);
        check("reset_paddr", PADDR, 32'd0);
        check("reset_pwdata", PWDATA, 32'd0);
        check("reset_pwrite_rdata", {31'd0, PWRITE} | rdata, 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);

        for (int i = 0; i < 8; i++)
            run_xfer(tbl[i].name, tbl[i].a, tbl[i].w, tbl[i].wd, tbl[i].lat, tbl[i].rd,
                     tbl[i].psel, tbl[i].cyc, tbl[i].err, tbl[i].rdata);

        // Back-to-back: transfer held through completion, addr changed meanwhile.
        lat_cfg = 0;
        for (int i = 0; i < NSLV; i++) slot_data[i] = $urandom;
        slot_data[1] = 32'h0BAD_BEEF;
        addr = 32'h1000_1010; write = 1'b0; wdata = '0; transfer = 1'b1;
        @(posedge PCLK); #1;
        addr = 32'h1000_4020; write = 1'b1; wdata = 32'h0000_DEAD;
        @(negedge PCLK);
        check("b2b_setup_ready", 32'(ready), 32'd0);
        check("b2b_first_paddr", PADDR, 32'h1000_1010);
        @(negedge PCLK);
        check("b2b_first_ready", 32'(ready), 32'd1);
        check("b2b_first_rdata", rdata, 32'h0BAD_BEEF);
        @(posedge PCLK); #1;
        transfer = 1'b0;
        @(negedge PCLK);
        check("b2b_second_paddr", PADDR, 32'h1000_4020);
        check("b2b_second_setup", {25'd0, PSEL, PENABLE, ready}, {25'd0, 5'b10000, 1'b0, 1'b0});
        @(negedge PCLK);
        check("b2b_second_done", {29'd0, ready, err, PWRITE}, {29'd0, 1'b1, 1'b0, 1'b1});
        check("b2b_second_rdata", rdata, 32'd0);
        @(negedge PCLK);

        // Reset while in ACCESS on a slave that never answers.
        lat_cfg = 1000;
        addr = 32'h1000_3000; write = 1'b0; transfer = 1'b1;
        @(posedge PCLK); #1;
        transfer = 1'b0;
        repeat (2) @(negedge PCLK);
        check("rst_mid_penable", {27'd0, PSEL, PENABLE}, {27'd0, 5'b01000, 1'b1});
        PRESET = 1'b1;
        #1;
        check("rst_mid_outputs", {25'd0, PSEL, PENABLE, ready}, 32'd0);
        check("rst_mid_paddr", PADDR, 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        saw_ready = 1'b0;
        repeat (25) begin
            @(negedge PCLK);
            if (ready === 1'b1 || PENABLE === 1'b1) saw_ready = 1'b1;
        end
        check("rst_no_ready_after", 32'(saw_ready), 32'd0);

        // Randomized requests against a closed-form latency/result model.
        for (int k = 0; k < 60; k++) begin
            slot = 4'($urandom_range(0, 7));
            base = ($urandom_range(0, 5) == 0) ? $urandom : 32'h1000_0000;
            a    = {base[31:16], slot, 12'($urandom)};
            w    = 1'($urandom);
            wd   = $urandom;
            rd   = $urandom;
            lat  = ($urandom_range(0, 9) < 6) ? $urandom_range(0, 3) : $urandom_range(10, 25);
            mapped = (a[31:16] == 16'h1000) && (a[15:12] < NSLV);
            ok     = mapped && (lat + 1 <= TIMEOUT);
            n      = !mapped ? 1 : ((lat + 1 <= TIMEOUT) ? lat + 1 : TIMEOUT);
            e_psel = mapped ? 5'(1 << a[15:12]) : 5'd0;
            e_rdata = (ok && !w) ? rd : 32'd0;
            run_xfer($sformatf("rand%0d", k), a, w, wd, lat, rd, e_psel, 1 + n, !ok, e_rdata);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
